// File: rtl/scoreboard_match_ctrl_if.sv
// Event/score bundle between the button processors, display path and the match controller.
interface scoreboard_match_ctrl_if #(parameter int BW = 8);
  logic          up_a_i;
  logic          down_a_i;
  logic          up_b_i;
  logic          down_b_i;
  logic          new_match_i;
  logic [BW-1:0] score_a_o;
  logic [BW-1:0] score_b_o;
  logic [BW-1:0] disp_val_o;
  logic          disp_sel_o;
  logic          blank_o;
  logic [1:0]    winner_o;
  logic [1:0]    state_o;

  modport master (
    output up_a_i, down_a_i, up_b_i, down_b_i, new_match_i,
    input  score_a_o, score_b_o, disp_val_o, disp_sel_o, blank_o, winner_o, state_o
  );
  modport slave (
    input  up_a_i, down_a_i, up_b_i, down_b_i, new_match_i,
    output score_a_o, score_b_o, disp_val_o, disp_sel_o, blank_o, winner_o, state_o
  );
endinterface

// File: rtl/scoreboard_match_ctrl.sv
// Two-player match controller: scores, win detection, shared display scheduling and winner blink.
// Optional WIN_BY_TWO_EN: a win additionally needs a 2-point lead (deuce rule).
module scoreboard_match_ctrl #(
  parameter int BW          = 8,
  parameter int WIN_SCORE   = 11,
  parameter int DISP_TICKS  = 1000,
  parameter int BLINK_TICKS = 250
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  scoreboard_match_ctrl_if.slave sb
);
  localparam int TW  = (DISP_TICKS  > 1) ? $clog2(DISP_TICKS)  : 1;
  localparam int KW  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(DISP_TICKS - 1);
  localparam logic [KW-1:0] BLINK_LAST = KW'(BLINK_TICKS - 1);
  localparam logic [BW:0]   WIN_W      = (BW+1)'(WIN_SCORE);
  localparam logic [BW-1:0] MAX_SCORE  = {BW{1'b1}};

  typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, WON = 2'b10} state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] score_a_q, score_a_d, score_b_q, score_b_d;
  logic [BW-1:0] disp_val_q, disp_val_d;
  logic [1:0]    winner_q, winner_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [KW-1:0] blink_q, blink_d;
  logic          disp_sel_q, disp_sel_d;
  logic          blank_q, blank_d;
  logic [BW-1:0] nxt_a, nxt_b;
  logic          win_a, win_b;

  // Post-update scores; simultaneous up/down cancels, both ends saturate.
  always_comb begin
    nxt_a = score_a_q;
    nxt_b = score_b_q;
    if (sb.up_a_i && !sb.down_a_i && score_a_q != MAX_SCORE) nxt_a = score_a_q + 1'b1;
    else if (sb.down_a_i && !sb.up_a_i && score_a_q != '0)   nxt_a = score_a_q - 1'b1;
    if (sb.up_b_i && !sb.down_b_i && score_b_q != MAX_SCORE) nxt_b = score_b_q + 1'b1;
    else if (sb.down_b_i && !sb.up_b_i && score_b_q != '0)   nxt_b = score_b_q - 1'b1;
  end

`ifdef WIN_BY_TWO_EN
  assign win_a = ({1'b0, nxt_a} >= WIN_W) && ({1'b0, nxt_a} >= {1'b0, nxt_b} + (BW+1)'(2));
  assign win_b = ({1'b0, nxt_b} >= WIN_W) && ({1'b0, nxt_b} >= {1'b0, nxt_a} + (BW+1)'(2));
`else
  assign win_a = ({1'b0, nxt_a} >= WIN_W) && (nxt_a > nxt_b);
  assign win_b = ({1'b0, nxt_b} >= WIN_W) && (nxt_b > nxt_a);
`endif

  always_comb begin
    state_d    = state_q;
    score_a_d  = score_a_q;
    score_b_d  = score_b_q;
    winner_d   = winner_q;
    tick_d     = tick_q;
    disp_sel_d = disp_sel_q;
    blink_d    = blink_q;
    blank_d    = blank_q;
    disp_val_d = disp_sel_q ? score_b_q : score_a_q;

    if (sb.new_match_i) begin
      state_d    = PLAY;
      score_a_d  = '0;
      score_b_d  = '0;
      winner_d   = 2'b00;
      tick_d     = '0;
      disp_sel_d = 1'b0;
      blink_d    = '0;
      blank_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE, PLAY: begin
          blank_d = 1'b0;
          if (tick_q == TICK_LAST) begin
            tick_d     = '0;
            disp_sel_d = ~disp_sel_q;
          end else begin
            tick_d = tick_q + 1'b1;
          end
          if (state_q == PLAY) begin
            score_a_d = nxt_a;
            score_b_d = nxt_b;
            // Winner's side takes the display on the winning edge itself.
            if (win_a || win_b) begin
              state_d    = WON;
              winner_d   = win_a ? 2'b01 : 2'b10;
              disp_sel_d = win_b;
              blink_d    = '0;
              blank_d    = 1'b0;
            end
          end
        end
        WON: begin
          if (blink_q == BLINK_LAST) begin
            blink_d = '0;
            blank_d = ~blank_q;
          end else begin
            blink_d = blink_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      score_a_q  <= '0;
      score_b_q  <= '0;
      disp_val_q <= '0;
      winner_q   <= 2'b00;
      tick_q     <= '0;
      disp_sel_q <= 1'b0;
      blink_q    <= '0;
      blank_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      score_a_q  <= score_a_d;
      score_b_q  <= score_b_d;
      disp_val_q <= disp_val_d;
      winner_q   <= winner_d;
      tick_q     <= tick_d;
      disp_sel_q <= disp_sel_d;
      blink_q    <= blink_d;
      blank_q    <= blank_d;
    end
  end

  assign sb.score_a_o  = score_a_q;
  assign sb.score_b_o  = score_b_q;
  assign sb.disp_val_o = disp_val_q;
  assign sb.disp_sel_o = disp_sel_q;
  assign sb.blank_o    = blank_q;
  assign sb.winner_o   = winner_q;
  assign sb.state_o    = state_q;
endmodule
